tone_sequencer: RTL
===================

Name: tone_sequencer

Overview:
Controller that configures the board's clock divider to play notes. It drives the divider's 28-bit `finalcount` and a tone enable.
- Manual mode: plays the note selected on the switches, continuously.
- Sequence mode: steps through a captured list of notes on a start pulse, with a fixed note duration and an inter-note gap.
- Sits between the switch/key inputs and the divider; the top level ANDs the divider output with `tone_en` before the audio path.

Parameters:
- CLK_HZ, 50_000_000: frequency of inclk, in Hz; used to build the note table.
- NOTE_TICKS, 25_000_000: inclk cycles each note sounds; must be >= 1.
- GAP_TICKS, 2_500_000: inclk cycles of silence after each note; 0 means no gap.
- SEQ_LEN, 8: number of steps in a sequence; legal range 1..16.

Ports:
- inclk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request to begin a sequence; sampled only in IDLE.
- mode_manual, input, 1: 1 selects manual tone, 0 selects sequence mode.
- manual_note, input, 3: note index used in manual mode.
- seq_notes, input, SEQ_LEN*3: note list; step k occupies bits [3k+2:3k].
- finalcount, output, 28: divide count driven to the clock divider.
- tone_en, output, 1: 1 means the tone is audible.
- busy, output, 1: high while a sequence is running.
- done, output, 1: one-cycle pulse when a sequence ends.
- step_idx, output, $clog2(SEQ_LEN) (min 1): current step index.
- note_out, output, 3: note index currently applied.

Behaviour:
- Clocking and reset:
  - Single clock domain; every output is registered.
  - Reset: state=IDLE, finalcount=NOTE_COUNT[0], tone_en=0, busy=0, done=0, step_idx=0, note_out=0, timer=0.
  - Reset asserted mid-sequence returns to IDLE at that edge; there is no done pulse.
- Note table:
  - NOTE_COUNT[n] = CLK_HZ / NOTE_HZ[n], integer truncation, evaluated at elaboration.
  - NOTE_HZ = {523, 587, 659, 698, 783, 880, 987, 1046}.
  - At 50 MHz this gives 95602, 85178, 75872, 71633, 63856, 56818, 50658, 47801.
  - All 8 indices are valid.
- States: IDLE, PLAY, GAP.
- IDLE:
  - If mode_manual=1: next edge sets note_out=manual_note, finalcount=NOTE_COUNT[manual_note], tone_en=1 (1-cycle latency from a switch change). start is ignored.
  - If mode_manual=0: tone_en=0 and finalcount holds its last value.
  - If mode_manual=0 and start=1 at an edge: capture seq_notes into a shadow register, step_idx=0, load note 0 (finalcount, note_out), tone_en=1, busy=1, timer=0, then enter PLAY.
- PLAY:
  - Timer increments each cycle; the state lasts exactly NOTE_TICKS cycles.
  - On the last cycle: if GAP_TICKS>0, go to GAP with tone_en=0 and timer=0.
  - Otherwise, advance as at the end of GAP.
- GAP:
  - Lasts exactly GAP_TICKS cycles; finalcount is held.
  - At the end, if step_idx < SEQ_LEN-1: step_idx+1, load the next note, tone_en=1, go to PLAY.
  - Otherwise go to IDLE with busy=0, done=1 for that one cycle, and step_idx=0.
- start and mode_manual are ignored while busy. The sequence always completes; manual mode takes effect in the cycle after return to IDLE.
- Changes to seq_notes while busy have no effect (shadow copy).
- start held high across the done cycle re-triggers a new sequence the following cycle. This is legal and back-to-back.
- The divider's internal counter is never reset by this block. A new finalcount takes effect at the divider's next terminal count.
- Timer width = $clog2(max(NOTE_TICKS, GAP_TICKS)+1); comparisons must not overflow.

Decomposition:
- Package tone_pkg:
  - note index typedef (3-bit),
  - NOTE_HZ constant array,
  - function note_count(clk_hz, idx) returning 28 bits,
  - state enum {IDLE, PLAY, GAP}.
- One sub-module, tick_timer: loadable up-counter with a terminal-count flag, reused for the PLAY and GAP durations.

Test Plan:
Benches use CLK_HZ=50_000_000, NOTE_TICKS=10, GAP_TICKS=2, SEQ_LEN=4 unless noted.
1. Reset held 3 cycles, then released with mode_manual=0 -> finalcount=95602, tone_en=0, busy=0, done=0.
2. Manual mode: mode_manual=1, manual_note=5 -> 1 cycle later finalcount=56818, tone_en=1. Change to 7 -> finalcount=47801 next cycle. start pulses -> busy stays 0.
3. Sequence: seq_notes={3,2,1,0} (step 0 = note 0), start pulse ->
   - busy rises the next cycle;
   - finalcount steps 95602, 85178, 75872, 71633;
   - each note is 10 cycles with tone_en=1, followed by 2 cycles with tone_en=0;
   - done pulses exactly once, 48 cycles after busy rises; busy=0 on the same cycle.
4. Mid-sequence disturbance: change seq_notes and pulse start during step 1 -> the sequence is unchanged. Assert reset at step 2 -> IDLE at the next edge, tone_en=0, no done.
5. GAP_TICKS=0, SEQ_LEN=1, note 6 -> tone_en high for exactly 10 cycles, finalcount=50658, then done.
6. start held high continuously -> a second sequence begins the cycle after done; busy is low for exactly that one cycle.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared types and the note table for the tone sequencer.
// Note counts come from integer division of the clock rate by each note's pitch.
package tone_pkg;

    typedef logic [2:0] note_t;

    localparam int NUM_NOTES = 8;

    // C5 up to C6 in Hz
    localparam int NOTE_HZ [NUM_NOTES] = '{523, 587, 659, 698, 783, 880, 987, 1046};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic logic [27:0] note_count(input int clk_hz, input note_t idx);
        return 28'(clk_hz / NOTE_HZ[idx]);
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable up-counter whose terminal flag is raised when the count equals 'last'.
// The sequencer reprograms 'last' for each state it times.
module tick_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == last);

endmodule

// File: rtl/tone_sequencer.sv
// Drives the clock divider's finalcount and a tone enable, either from the
// manual note switches or by stepping through a captured list of notes.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int  CLK_HZ     = 50_000_000,
    parameter int  NOTE_TICKS = 25_000_000,
    parameter int  GAP_TICKS  = 2_500_000,
    parameter int  SEQ_LEN    = 8,
    localparam int STEP_W     = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
    input  logic                 inclk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode_manual,
    input  note_t                manual_note,
    input  logic [SEQ_LEN*3-1:0] seq_notes,
    output logic [27:0]          finalcount,
    output logic                 tone_en,
    output logic                 busy,
    output logic                 done,
    output logic [STEP_W-1:0]    step_idx,
    output note_t                note_out
);

    localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int TIMER_W   = $clog2(MAX_TICKS + 1);

    // Timer compares against the final cycle index of each state
    localparam logic [TIMER_W-1:0] PLAY_LAST = TIMER_W'(NOTE_TICKS - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [STEP_W-1:0]  LAST_STEP = STEP_W'(SEQ_LEN - 1);

    localparam logic [27:0] NOTE_COUNT [NUM_NOTES] = '{
        note_count(CLK_HZ, 3'd0), note_count(CLK_HZ, 3'd1),
        note_count(CLK_HZ, 3'd2), note_count(CLK_HZ, 3'd3),
        note_count(CLK_HZ, 3'd4), note_count(CLK_HZ, 3'd5),
        note_count(CLK_HZ, 3'd6), note_count(CLK_HZ, 3'd7)
    };

    state_t               state_q, state_d;
    logic [27:0]          fc_q, fc_d;
    logic                 tone_q, tone_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [STEP_W-1:0]    step_q, step_d;
    note_t                note_q, note_d;
    logic [SEQ_LEN*3-1:0] shadow_q, shadow_d;

    logic                 timer_clear;
    logic                 timer_en;
    logic [TIMER_W-1:0]   timer_last;
    logic                 timer_tc;
    logic                 advance;
    logic [STEP_W-1:0]    next_step;
    note_t                next_note;

    tick_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk   (inclk),
        .reset (reset),
        .clear (timer_clear),
        .en    (timer_en),
        .last  (timer_last),
        .tc    (timer_tc)
    );

    assign next_step = step_q + 1'b1;

    always_comb begin
        next_note = '0;
        for (int k = 0; k < SEQ_LEN; k++) begin
            if (STEP_W'(k) == next_step) begin
                next_note = shadow_q[3*k +: 3];
            end
        end
    end

    always_ff @(posedge inclk) begin
        if (reset) begin
            state_q  <= IDLE;
            fc_q     <= NOTE_COUNT[0];
            tone_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            step_q   <= '0;
            note_q   <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            fc_q     <= fc_d;
            tone_q   <= tone_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            step_q   <= step_d;
            note_q   <= note_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fc_d        = fc_q;
        tone_d      = tone_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        step_d      = step_q;
        note_d      = note_q;
        shadow_d    = shadow_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        timer_last  = PLAY_LAST;
        advance     = 1'b0;

        case (state_q)
            IDLE: begin
                timer_clear = 1'b1;
                if (mode_manual) begin
                    note_d = manual_note;
                    fc_d   = NOTE_COUNT[manual_note];
                    tone_d = 1'b1;
                end else if (start) begin
                    shadow_d = seq_notes;
                    step_d   = '0;
                    note_d   = seq_notes[2:0];
                    fc_d     = NOTE_COUNT[seq_notes[2:0]];
                    tone_d   = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = PLAY;
                end else begin
                    tone_d = 1'b0;
                end
            end
            PLAY: begin
                timer_last = PLAY_LAST;
                if (timer_tc) begin
                    timer_clear = 1'b1;
                    if (GAP_TICKS > 0) begin
                        tone_d  = 1'b0;
                        state_d = GAP;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    timer_en = 1'b1;
                end
            end
            GAP: begin
                timer_last = GAP_LAST;
                if (timer_tc) begin
                    timer_clear = 1'b1;
                    advance     = 1'b1;
                end else begin
                    timer_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // End of a note slot: move to the next step or finish the sequence
        if (advance) begin
            if (step_q != LAST_STEP) begin
                step_d  = next_step;
                note_d  = next_note;
                fc_d    = NOTE_COUNT[next_note];
                tone_d  = 1'b1;
                state_d = PLAY;
            end else begin
                step_d  = '0;
                tone_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    assign finalcount = fc_q;
    assign tone_en    = tone_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign step_idx   = step_q;
    assign note_out   = note_q;

endmodule
